// File: rtl/rv32i_mc_controller.sv
// Multi-cycle RV32I control unit: FETCH -> DECODE -> EXEC -> (MEM) -> WB per instruction.
// Latency: 4 cycles per ALU/branch/jump instruction, 5+ for loads/stores, plus memory wait cycles.
// Backpressure: stalls in FETCH/MEM until the memory's ready; a bounded wait traps on timeout.
module rv32i_mc_controller #(
    parameter int MEM_TIMEOUT  = 255,
    parameter bit TRAP_ILLEGAL = 1'b1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_wr,
    output logic             dmem_req,
    output logic             pc_wr,
    output logic             reg_wr,
    output logic [3:0]       alu_op,
    output logic [2:0]       immsrc,
    output logic             sel_A,
    output logic             sel_B,
    output logic [1:0]       wb_sel,
    output logic [2:0]       br_type,
    output logic [2:0]       readcontrol,
    output logic [2:0]       writecontrol,
    output logic             hlt,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;
    localparam logic [2:0] S_TRAP   = 3'd6;

    localparam logic [6:0] OP_LOAD  = 7'h03;
    localparam logic [6:0] OP_IMM   = 7'h13;
    localparam logic [6:0] OP_AUIPC = 7'h17;
    localparam logic [6:0] OP_STORE = 7'h23;
    localparam logic [6:0] OP_REG   = 7'h33;
    localparam logic [6:0] OP_LUI   = 7'h37;
    localparam logic [6:0] OP_BR    = 7'h63;
    localparam logic [6:0] OP_JALR  = 7'h67;
    localparam logic [6:0] OP_JAL   = 7'h6F;
    localparam logic [6:0] OP_HALT  = 7'h46;

    // Wait counter runs 0..MEM_TIMEOUT-1; the last value with ready still low is the timeout cycle.
    localparam int         TW      = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    logic [2:0]       r_state;
    logic [1:0]       r_trap_cause;
    logic [TW-1:0]    r_wait;
    logic [CNT_W-1:0] r_instret;

    // Registered control bundle, loaded at the end of DECODE.
    logic [3:0] r_alu_op;
    logic [2:0] r_immsrc;
    logic       r_sel_A;
    logic       r_sel_B;
    logic [1:0] r_wb_sel;
    logic       r_reg_wr;
    logic       r_is_mem;
    logic [2:0] r_br_type;
    logic [2:0] r_readcontrol;
    logic [2:0] r_writecontrol;

    logic [6:0] w_opc;
    logic [2:0] w_f3;
    logic       w_f7b5;
    logic       w_timeout;
    logic [2:0] w_next;
    logic [1:0] w_cause;

    logic [3:0] w_alu_op;
    logic [2:0] w_immsrc;
    logic       w_sel_A;
    logic       w_sel_B;
    logic [1:0] w_wb_sel;
    logic       w_reg_wr;
    logic       w_is_mem;
    logic [2:0] w_br_type;
    logic [2:0] w_readcontrol;
    logic [2:0] w_writecontrol;
    logic [3:0] w_alu_ri;
    logic       w_unused_instr;

    assign w_opc          = instr[6:0];
    assign w_f3           = instr[14:12];
    assign w_f7b5         = instr[30];
    assign w_unused_instr = ^{instr[31], instr[29:15], instr[11:7]};
    assign w_timeout      = (MEM_TIMEOUT != 0) && (r_wait == TO_LAST);

    // ALU op for R/I types; funct7[5] selects sub only for R, sra for both.
    always_comb begin
        w_alu_ri = 4'd0;
        case (w_f3)
            3'd0: w_alu_ri = (w_opc == OP_REG && w_f7b5) ? 4'd1 : 4'd0;
            3'd1: w_alu_ri = 4'd5;
            3'd2: w_alu_ri = 4'd9;
            3'd3: w_alu_ri = 4'd8;
            3'd4: w_alu_ri = 4'd2;
            3'd5: w_alu_ri = w_f7b5 ? 4'd7 : 4'd6;
            3'd6: w_alu_ri = 4'd3;
            default: w_alu_ri = 4'd4;
        endcase
    end

    // Opcode decode into the next control bundle; unknown/halt opcodes yield an inert bundle.
    always_comb begin
        w_alu_op       = 4'd0;
        w_immsrc       = 3'd0;
        w_sel_A        = 1'b0;
        w_sel_B        = 1'b0;
        w_wb_sel       = 2'd0;
        w_reg_wr       = 1'b0;
        w_is_mem       = 1'b0;
        w_br_type      = 3'd2;
        w_readcontrol  = 3'd7;
        w_writecontrol = 3'd7;
        case (w_opc)
            OP_LOAD: begin
                w_sel_A = 1'b1; w_sel_B = 1'b1; w_wb_sel = 2'd2; w_reg_wr = 1'b1;
                w_is_mem = 1'b1; w_readcontrol = w_f3;
            end
            OP_IMM: begin
                w_sel_A = 1'b1; w_sel_B = 1'b1; w_wb_sel = 2'd1; w_reg_wr = 1'b1;
                w_alu_op = w_alu_ri;
            end
            OP_AUIPC: begin
                w_immsrc = 3'd3; w_sel_B = 1'b1; w_wb_sel = 2'd1; w_reg_wr = 1'b1;
            end
            OP_STORE: begin
                w_immsrc = 3'd1; w_sel_A = 1'b1; w_sel_B = 1'b1;
                w_is_mem = 1'b1; w_writecontrol = w_f3;
            end
            OP_REG: begin
                w_sel_A = 1'b1; w_wb_sel = 2'd1; w_reg_wr = 1'b1; w_alu_op = w_alu_ri;
            end
            OP_LUI: begin
                w_immsrc = 3'd4; w_sel_A = 1'b1; w_sel_B = 1'b1; w_wb_sel = 2'd1;
                w_reg_wr = 1'b1; w_alu_op = 4'd10;
            end
            OP_BR: begin
                w_immsrc = 3'd2; w_sel_B = 1'b1; w_br_type = w_f3;
            end
            OP_JALR: begin
                w_sel_A = 1'b1; w_sel_B = 1'b1; w_reg_wr = 1'b1; w_br_type = 3'd3;
            end
            OP_JAL: begin
                w_immsrc = 3'd3; w_sel_B = 1'b1; w_reg_wr = 1'b1; w_br_type = 3'd3;
            end
            default: ;
        endcase
    end

    // Next-state logic; ready takes priority over a timeout in the same cycle.
    always_comb begin
        w_next  = r_state;
        w_cause = r_trap_cause;
        case (r_state)
            S_FETCH: begin
                if (imem_ready) begin
                    w_next = S_DECODE;
                end else if (w_timeout) begin
                    w_next  = S_TRAP;
                    w_cause = 2'd2;
                end
            end
            S_DECODE: begin
                case (w_opc)
                    OP_LOAD, OP_IMM, OP_AUIPC, OP_STORE, OP_REG,
                    OP_LUI, OP_BR, OP_JALR, OP_JAL: w_next = S_EXEC;
                    OP_HALT: w_next = S_HALT;
                    default: begin
                        if (TRAP_ILLEGAL) begin
                            w_next  = S_TRAP;
                            w_cause = 2'd1;
                        end else begin
                            w_next = S_EXEC;
                        end
                    end
                endcase
            end
            S_EXEC: w_next = r_is_mem ? S_MEM : S_WB;
            S_MEM: begin
                if (dmem_ready) begin
                    w_next = S_WB;
                end else if (w_timeout) begin
                    w_next  = S_TRAP;
                    w_cause = 2'd3;
                end
            end
            S_WB:    w_next = S_FETCH;
            S_HALT:  w_next = S_HALT;
            default: w_next = S_TRAP;
        endcase
    end

    // State, trap cause, wait counter (cleared on any state change) and retired count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_FETCH;
            r_trap_cause <= 2'd0;
            r_wait       <= '0;
            r_instret    <= '0;
        end else begin
            r_state      <= w_next;
            r_trap_cause <= w_cause;
            if (w_next != r_state) begin
                r_wait <= '0;
            end else if (r_state == S_FETCH || r_state == S_MEM) begin
                r_wait <= r_wait + 1'b1;
            end
            if (r_state == S_WB) begin
                r_instret <= r_instret + 1'b1;
            end
        end
    end

    // Control bundle capture at the end of DECODE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_op       <= 4'd0;
            r_immsrc       <= 3'd0;
            r_sel_A        <= 1'b0;
            r_sel_B        <= 1'b0;
            r_wb_sel       <= 2'd0;
            r_reg_wr       <= 1'b0;
            r_is_mem       <= 1'b0;
            r_br_type      <= 3'd2;
            r_readcontrol  <= 3'd7;
            r_writecontrol <= 3'd7;
        end else if (r_state == S_DECODE) begin
            r_alu_op       <= w_alu_op;
            r_immsrc       <= w_immsrc;
            r_sel_A        <= w_sel_A;
            r_sel_B        <= w_sel_B;
            r_wb_sel       <= w_wb_sel;
            r_reg_wr       <= w_reg_wr;
            r_is_mem       <= w_is_mem;
            r_br_type      <= w_br_type;
            r_readcontrol  <= w_readcontrol;
            r_writecontrol <= w_writecontrol;
        end
    end

    assign imem_req     = (r_state == S_FETCH);
    assign ir_wr        = (r_state == S_FETCH) && imem_ready;
    assign dmem_req     = (r_state == S_MEM);
    assign pc_wr        = (r_state == S_WB);
    assign reg_wr       = (r_state == S_WB) && r_reg_wr;
    assign alu_op       = r_alu_op;
    assign immsrc       = r_immsrc;
    assign sel_A        = r_sel_A;
    assign sel_B        = r_sel_B;
    assign wb_sel       = r_wb_sel;
    assign br_type      = r_br_type;
    assign readcontrol  = r_readcontrol;
    assign writecontrol = r_writecontrol;
    assign hlt          = (r_state == S_HALT);
    assign trap         = (r_state == S_TRAP);
    assign trap_cause   = r_trap_cause;
    assign state        = r_state;
    assign instret      = r_instret;

endmodule

// File: tb/tb_rv32i_mc_controller.sv
// Directed bench for rv32i_mc_controller: walks single instructions through the FSM.
// Inputs change 1 ns after the rising edge; outputs are sampled 2 ns after it.
// Memory ready latency is programmed per instruction to exercise waits and timeouts.
module tb_rv32i_mc_controller;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        imem_ready;
    logic        dmem_ready;
    logic        imem_req;
    logic        ir_wr;
    logic        dmem_req;
    logic        pc_wr;
    logic        reg_wr;
    logic [3:0]  alu_op;
    logic [2:0]  immsrc;
    logic        sel_A;
    logic        sel_B;
    logic [1:0]  wb_sel;
    logic [2:0]  br_type;
    logic [2:0]  readcontrol;
    logic [2:0]  writecontrol;
    logic        hlt;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [2:0]  state;
    logic [31:0] instret;

    int n_cmp = 0;
    int n_err = 0;

    // Per-run observations.
    int n_cyc, n_ireq, n_irwr, n_dreq, n_pcwr, n_regwr, n_regwr_bad;
    logic [3:0] cap_alu;
    logic [2:0] cap_imm, cap_br, cap_rc, cap_wc;
    logic       cap_a, cap_b;
    logic [1:0] cap_wb;

    rv32i_mc_controller #(
        .MEM_TIMEOUT (4),
        .TRAP_ILLEGAL(1'b1),
        .CNT_W       (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .imem_ready  (imem_ready),
        .dmem_ready  (dmem_ready),
        .imem_req    (imem_req),
        .ir_wr       (ir_wr),
        .dmem_req    (dmem_req),
        .pc_wr       (pc_wr),
        .reg_wr      (reg_wr),
        .alu_op      (alu_op),
        .immsrc      (immsrc),
        .sel_A       (sel_A),
        .sel_B       (sel_B),
        .wb_sel      (wb_sel),
        .br_type     (br_type),
        .readcontrol (readcontrol),
        .writecontrol(writecontrol),
        .hlt         (hlt),
        .trap        (trap),
        .trap_cause  (trap_cause),
        .state       (state),
        .instret     (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Run one instruction from FETCH until the FSM is back in FETCH (or parks in HALT/TRAP).
    // Fetch ready rises after iwait cycles, data ready after dwait MEM cycles; ready is held
    // high outside its request state to show it is ignored there.
    task automatic run(input logic [31:0] ins, input int iwait, input int dwait);
        int  icnt;
        int  dcnt;
        bit  left;
        bit  done;
        icnt = 0; dcnt = 0; left = 0; done = 0;
        n_cyc = 0; n_ireq = 0; n_irwr = 0; n_dreq = 0; n_pcwr = 0; n_regwr = 0; n_regwr_bad = 0;
        instr = ins;
        for (int c = 0; c < 40; c++) begin
            if (state == 3'd0) begin
                imem_ready = (icnt >= iwait);
                icnt++;
            end else begin
                imem_ready = 1'b1;
            end
            if (state == 3'd3) begin
                dmem_ready = (dcnt >= dwait);
                dcnt++;
            end else begin
                dmem_ready = 1'b1;
            end
            #1;
            n_cyc++;
            if (imem_req) n_ireq++;
            if (ir_wr)    n_irwr++;
            if (dmem_req) n_dreq++;
            if (pc_wr)    n_pcwr++;
            if (reg_wr)   n_regwr++;
            if (reg_wr && state != 3'd4) n_regwr_bad++;
            if (state == 3'd2) begin
                cap_alu = alu_op; cap_imm = immsrc; cap_a = sel_A; cap_b = sel_B;
                cap_wb = wb_sel; cap_br = br_type; cap_rc = readcontrol; cap_wc = writecontrol;
            end
            @(posedge clk);
            #1;
            if (state != 3'd0) left = 1;
            if (left && (state == 3'd0 || state == 3'd5 || state == 3'd6)) begin
                done = 1;
                break;
            end
        end
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        #1;
        chk("run_bound", 32'(done), 32'd1);
    endtask

    // Compare a completed instruction's captured bundle and strobe counts.
    task automatic expect_run(input string t, input int alu, input int a, input int b,
                              input int wb, input int imm, input int br, input int rc,
                              input int wc, input int regwr, input int dreq, input int cyc,
                              input int ret);
        chk({t, "_alu"},    32'(cap_alu), 32'(alu));
        chk({t, "_selA"},   32'(cap_a),   32'(a));
        chk({t, "_selB"},   32'(cap_b),   32'(b));
        chk({t, "_wbsel"},  32'(cap_wb),  32'(wb));
        chk({t, "_immsrc"}, 32'(cap_imm), 32'(imm));
        chk({t, "_brtype"}, 32'(cap_br),  32'(br));
        chk({t, "_rdctl"},  32'(cap_rc),  32'(rc));
        chk({t, "_wrctl"},  32'(cap_wc),  32'(wc));
        chk({t, "_regwr"},  32'(n_regwr), 32'(regwr));
        chk({t, "_regwr_outside_wb"}, 32'(n_regwr_bad), 32'd0);
        chk({t, "_pcwr"},   32'(n_pcwr),  32'd1);
        chk({t, "_irwr"},   32'(n_irwr),  32'd1);
        chk({t, "_dreq"},   32'(n_dreq),  32'(dreq));
        chk({t, "_cycles"}, 32'(n_cyc),   32'(cyc));
        chk({t, "_instret"}, instret,     32'(ret));
        chk({t, "_state"},  32'(state),   32'd0);
    endtask

    initial begin
        rst = 1'b1; instr = 32'h0; imem_ready = 1'b0; dmem_ready = 1'b0;
        #1;
        chk("rst_state",   32'(state),        32'd0);
        chk("rst_instret", instret,           32'd0);
        chk("rst_brtype",  32'(br_type),      32'd2);
        chk("rst_rdctl",   32'(readcontrol),  32'd7);
        chk("rst_wrctl",   32'(writecontrol), 32'd7);
        chk("rst_alu",     32'(alu_op),       32'd0);
        chk("rst_trap",    32'({trap, trap_cause, hlt}), 32'd0);
        chk("rst_strobes", 32'({reg_wr, pc_wr, dmem_req, ir_wr}), 32'd0);
        do_reset();

        //         tag     alu A  B  wb imm br rc wc rw dreq cyc ret
        run(32'h00500093, 0, 0);
        expect_run("addi",  0, 1, 1, 1, 0, 2, 7, 7, 1, 0,  4, 1);
        chk("addi_ireq", 32'(n_ireq), 32'd1);
        run(32'h0000A103, 0, 3);
        expect_run("lw",    0, 1, 1, 2, 0, 2, 2, 7, 1, 4,  8, 2);
        run(32'h40208033, 0, 0);
        expect_run("sub",   1, 1, 0, 1, 0, 2, 7, 7, 1, 0,  4, 3);
        run(32'h4010D093, 2, 0);
        expect_run("srai",  7, 1, 1, 1, 0, 2, 7, 7, 1, 0,  6, 4);
        chk("srai_ireq", 32'(n_ireq), 32'd3);
        run(32'h0020A023, 0, 0);
        expect_run("sw",    0, 1, 1, 0, 1, 2, 7, 2, 0, 1,  5, 5);
        run(32'h00208463, 0, 0);
        expect_run("beq",   0, 0, 1, 0, 2, 0, 7, 7, 0, 0,  4, 6);
        run(32'h008000EF, 0, 0);
        expect_run("jal",   0, 0, 1, 0, 3, 3, 7, 7, 1, 0,  4, 7);
        run(32'h123450B7, 0, 0);
        expect_run("lui",  10, 1, 1, 1, 4, 2, 7, 7, 1, 0,  4, 8);

        run(32'h00000046, 0, 0);
        chk("halt_state",   32'(state),  32'd5);
        chk("halt_hlt",     32'(hlt),    32'd1);
        chk("halt_instret", instret,     32'd8);
        chk("halt_pcwr",    32'(n_pcwr), 32'd0);
        repeat (3) @(posedge clk);
        #2;
        chk("halt_sticky",  32'({hlt, state}), 32'({1'b1, 3'd5}));
        chk("halt_strobes", 32'({reg_wr, pc_wr, dmem_req, imem_req, ir_wr}), 32'd0);

        do_reset();
        run(32'h0000007F, 0, 0);
        chk("ill_state", 32'(state),      32'd6);
        chk("ill_trap",  32'(trap),       32'd1);
        chk("ill_cause", 32'(trap_cause), 32'd1);
        chk("ill_pcwr",  32'(n_pcwr),     32'd0);
        chk("ill_hlt",   32'(hlt),        32'd0);
        repeat (3) @(posedge clk);
        #2;
        chk("ill_sticky",  32'({trap, trap_cause}), 32'({1'b1, 2'd1}));
        chk("ill_strobes", 32'({reg_wr, pc_wr, dmem_req, imem_req, ir_wr}), 32'd0);

        do_reset();
        run(32'h00500093, 100, 0);
        chk("ito_state", 32'(state),      32'd6);
        chk("ito_cause", 32'(trap_cause), 32'd2);
        chk("ito_ireq",  32'(n_ireq),     32'd4);
        chk("ito_irwr",  32'(n_irwr),     32'd0);

        do_reset();
        run(32'h0000A103, 0, 100);
        chk("dto_state", 32'(state),      32'd6);
        chk("dto_cause", 32'(trap_cause), 32'd3);
        chk("dto_dreq",  32'(n_dreq),     32'd4);
        chk("dto_regwr", 32'(n_regwr),    32'd0);
        chk("dto_pcwr",  32'(n_pcwr),     32'd0);
        chk("dto_instret", instret,       32'd0);

        // Asynchronous reset in the middle of a data-memory wait.
        do_reset();
        run(32'h00500093, 0, 0);
        chk("pre_instret", instret, 32'd1);
        instr = 32'h0000A103; imem_ready = 1'b1; dmem_ready = 1'b0;
        for (int c = 0; c < 10 && state != 3'd3; c++) begin
            @(posedge clk);
            #1;
            imem_ready = 1'b0;
        end
        chk("mid_reach_mem", 32'(state), 32'd3);
        @(posedge clk);
        #2;
        chk("mid_dreq",  32'(dmem_req),    32'd1);
        chk("mid_rdctl", 32'(readcontrol), 32'd2);
        rst = 1'b1;
        #1;
        chk("arst_state",   32'(state),       32'd0);
        chk("arst_dreq",    32'(dmem_req),    32'd0);
        chk("arst_rdctl",   32'(readcontrol), 32'd7);
        chk("arst_wbsel",   32'(wb_sel),      32'd0);
        chk("arst_brtype",  32'(br_type),     32'd2);
        chk("arst_instret", instret,          32'd0);
        chk("arst_trap",    32'({trap, trap_cause}), 32'd0);
        #5 rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rv32i_mc_controller.md
Name: rv32i_mc_controller

Overview:
- Multi-cycle RV32I control unit: FSM sequences FETCH → DECODE → EXEC → (MEM) → WB per instruction.
- Drives memory handshakes and datapath strobes.
- Registers the decoded control bundle once per instruction.
- Adds a memory-wait timeout, an illegal-opcode trap and a retired-instruction counter.

Parameters:
- MEM_TIMEOUT, 255, max cycles a memory request may wait for ready before TRAP; 0 disables the timeout.
- TRAP_ILLEGAL, 1, 1 = unknown opcode enters TRAP; 0 = treated as NOP (pc_wr only).
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr  in  32  current instruction from IR; stable from DECODE through WB.
- imem_ready  in  1  instruction memory data valid; sampled while imem_req=1.
- dmem_ready  in  1  data memory access complete; sampled while dmem_req=1.
- imem_req  out  1  fetch request.
- ir_wr  out  1  IR load strobe.
- dmem_req  out  1  data memory request.
- pc_wr  out  1  PC update strobe.
- reg_wr  out  1  register file write strobe.
- alu_op  out  4  ALU operation code.
- immsrc  out  3  immediate format select.
- sel_A  out  1  ALU A select (0 = PC, 1 = rs1).
- sel_B  out  1  ALU B select (0 = rs2, 1 = imm).
- wb_sel  out  2  writeback select (0 = PC+4, 1 = ALU, 2 = memory).
- br_type  out  3  branch condition code to branch unit.
- readcontrol  out  3  load width code.
- writecontrol  out  3  store width code.
- hlt  out  1  halted.
- trap  out  1  illegal opcode or memory timeout; sticky.
- trap_cause  out  2  0 = none, 1 = illegal, 2 = imem timeout, 3 = dmem timeout.
- state  out  3  FSM state (debug).
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, TRAP=6.
- rst (async) clears all registered outputs, counters and trap_cause. Bundle resets to 0, br_type to 2, readcontrol/writecontrol to 7. State → FETCH.
- FETCH:
  - imem_req=1 until imem_ready=1.
  - In the ready cycle, ir_wr=1 (combinational, same cycle); next state DECODE.
  - If imem_ready stays low for MEM_TIMEOUT cycles → TRAP, cause 2.
- DECODE (1 cycle): opcode decoded from instr[6:0]; bundle registered at the end of the cycle, valid from EXEC onward.
  - 0x03 L: immsrc 0, A1, B1, wb 2, reg_wr 1.
  - 0x13 I: immsrc 0, A1, B1, wb 1, reg_wr 1.
  - 0x17 auipc: immsrc 3, A0, B1, wb 1, reg_wr 1, alu 0.
  - 0x23 S: immsrc 1, A1, B1, reg_wr 0.
  - 0x33 R: A1, B0, wb 1, reg_wr 1.
  - 0x37 lui: immsrc 4, A1, B1, wb 1, reg_wr 1, alu 10.
  - 0x63 B: immsrc 2, A0, B1, reg_wr 0.
  - 0x67 jalr: immsrc 0, A1, B1, wb 0, reg_wr 1.
  - 0x6F jal: immsrc 3, A0, B1, wb 0, reg_wr 1.
  - 0x46 → HALT; any other opcode → TRAP, cause 1 (or NOP path when TRAP_ILLEGAL=0).
- alu_op for R/I, keyed on funct3 and funct7[5]; funct7[5] is honoured for I only when funct3=5:
  - add/addi 0; sub 1 (R only); xor 2; or 3; and 4; sll 5; srl 6; sra 7; sltu 8; slt 9.
  - All other instructions use alu_op 0, except lui (10).
- br_type: funct3 for B; 3 for jal/jalr; 2 otherwise.
- readcontrol = funct3 for L, else 7. writecontrol = funct3 for S, else 7.
- EXEC (1 cycle): L/S → MEM; others → WB.
- MEM:
  - dmem_req=1 until dmem_ready=1, then → WB.
  - Timeout → TRAP, cause 3; no reg_wr and no pc_wr are issued.
- WB (1 cycle): pc_wr=1; reg_wr=bundle reg_wr; instret += 1 (wraps at 2^CNT_W); → FETCH.
- reg_wr is 0 in every state except WB.
- The timeout counter clears on every state entry.
- HALT: hlt=1, all strobes 0, stays until reset; instret does not count halt.
- TRAP: trap=1, all strobes 0, stays until reset.
- Ready asserted in the same cycle the request first rises is accepted: zero wait, 1-cycle stage.
- Ready while no request is outstanding is ignored.

Test Plan:
- addi x1,x0,5 (0x00500093), imem_ready immediate → FETCH,DECODE,EXEC,WB. reg_wr=1 only in WB; alu_op=0, sel_B=1, wb_sel=1; instret=1 after 4 cycles.
- lw (0x0000A103) with dmem_ready delayed 3 cycles → dmem_req high 4 cycles; readcontrol=2, wb_sel=2; reg_wr pulses once.
- sub (0x40208033) then srai (0x4010D093) → alu_op 1 then 7. sw (0x0020A023) → writecontrol=2, reg_wr=0, pc_wr pulses.
- opcode 0x7F → trap=1, trap_cause=1, no pc_wr. Opcode 0x46 → hlt=1 with instret unchanged.
- MEM_TIMEOUT=4, dmem_ready held low → TRAP after 4 MEM cycles, cause 3. Assert rst mid-MEM → immediate FETCH with all outputs at reset values.
